dev_uart_tx: RTL and testbench



---
 rtl/dev_uart_tx.sv | 204 ++++++++++++++++++++
 tb/tb_dev_uart_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dev_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the 0x7xxx device window, with a TX FIFO and a programmable baud divisor.
// Latency: a push into an empty FIFO with the line idle is popped on the next edge, and the start bit drives tx after that edge.
// Backpressure: none on the bus; a TXDATA write while the FIFO is full is dropped and sets the sticky overflow flag.
module dev_uart_tx #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] dev_addr,
   input  logic [15:0] dev_wdata,
   input  logic        dev_wen,
   output logic [15:0] dev_rdata,
   output logic        tx
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);

   localparam logic [11:0] OFF_TXDATA  = 12'h000;
   localparam logic [11:0] OFF_STATUS  = 12'h001;
   localparam logic [11:0] OFF_DIVISOR = 12'h002;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // Register state
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic [15:0]   r_div;
   state_t        r_state;
   logic [7:0]    r_shift;
   logic [2:0]    r_bit_idx;
   logic [15:0]   r_period;
   logic [15:0]   r_baud_cnt;
   logic          r_tx;

   // Decode and FIFO handshake
   logic [11:0] w_offset;
   logic        w_unused_addr;
   logic        w_full;
   logic        w_nonempty;
   logic        w_push_req;
   logic        w_push;
   logic        w_pop;
   logic        w_bit_end;
   logic [15:0] w_div_eff;
   logic [7:0]  w_head;

   assign w_offset      = dev_addr[11:0];
   assign w_unused_addr = ^dev_addr[15:12];
   assign w_full        = (r_count == CNT_MAX);
   assign w_nonempty    = (r_count != '0);
   assign w_push_req    = dev_wen && (w_offset == OFF_TXDATA);
   // Full is judged on the registered count, so a same-edge pop never rescues a write.
   assign w_push        = w_push_req && !w_full;
   assign w_bit_end     = (r_baud_cnt == r_period - 16'd1);
   // A zero divisor would never reach a bit boundary; run it as one clock per bit.
   assign w_div_eff     = (r_div == 16'd0) ? 16'd1 : r_div;
   assign w_head        = r_mem[r_rd_ptr];
   // Pop when idle with data, or at the end of a stop bit so frames run back to back.
   assign w_pop         = w_nonempty &&
                          ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

   assign tx = r_tx;

   // FIFO storage; contents need no reset because count/pointers gate every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= dev_wdata[7:0];
      end
   end

   // FIFO pointers and occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overflow flag and the baud divisor register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
         r_div <= DIV_RESET;
      end else begin
         if (w_push_req && w_full) begin
            r_ovf <= 1'b1;
         end else if (dev_wen && (w_offset == OFF_STATUS) && dev_wdata[3]) begin
            r_ovf <= 1'b0;
         end
         if (dev_wen && (w_offset == OFF_DIVISOR)) begin
            r_div <= dev_wdata;
         end
      end
   end

   // Transmit FSM with registered tx; the bit period is frozen for the whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_tx       <= 1'b1;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_period   <= 16'd1;
         r_baud_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx       <= 1'b1;
               r_baud_cnt <= '0;
               if (w_pop) begin
                  r_shift   <= w_head;
                  r_period  <= w_div_eff;
                  r_bit_idx <= '0;
                  r_tx      <= 1'b0;
                  r_state   <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_tx       <= r_shift[0];
                  r_state    <= S_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  if (w_pop) begin
                     r_shift   <= w_head;
                     r_period  <= w_div_eff;
                     r_bit_idx <= '0;
                     r_tx      <= 1'b0;
                     r_state   <= S_START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 16'd1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Zero-wait-state read mux; reads have no side effects.
   always_comb begin
      dev_rdata = 16'h0000;
      case (w_offset)
         OFF_STATUS: begin
            dev_rdata[0]    = w_full;
            dev_rdata[1]    = !w_nonempty;
            dev_rdata[2]    = (r_state != S_IDLE);
            dev_rdata[3]    = r_ovf;
            dev_rdata[12:8] = 5'(r_count);
         end
         OFF_DIVISOR: dev_rdata = r_div;
         default:     dev_rdata = 16'h0000;
      endcase
   end

endmodule

// File: tb/tb_dev_uart_tx.sv
// Bench for dev_uart_tx: register-map vectors, directed frame sequences and random traffic.
// Every cycle tx and the read data are compared with a frame-level model (queue + frame start time).
// The model knows nothing of the RTL states; it places each bit by elapsed time / period.
module tb_dev_uart_tx;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] dev_addr = 16'h7001;
   logic [15:0] dev_wdata = 16'h0000;
   logic        dev_wen = 1'b0;
   logic [15:0] dev_rdata;
   logic        tx;

   dev_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dev_addr  (dev_addr),
      .dev_wdata (dev_wdata),
      .dev_wen   (dev_wen),
      .dev_rdata (dev_rdata),
      .tx        (tx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: byte queue, sticky flag, divisor, and the current frame as (start edge, period, byte).
   logic [7:0] m_q[$];
   bit         m_ovf;
   bit         m_busy;
   int         m_div;
   int         m_n;
   int         m_fs;
   int         m_p;
   logic [7:0] m_byte;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_ovf  = 1'b0;
      m_busy = 1'b0;
      m_div  = 434;
      m_n    = 0;
      m_fs   = 0;
      m_p    = 1;
      m_byte = 8'h00;
   endtask

   // One rising edge: end of frame, then pop (pre-edge contents), then bus write.
   task automatic m_step(input logic wen, input logic [15:0] addr, input logic [15:0] wdata);
      bit full_pre;
      m_n++;
      full_pre = (m_q.size() == DEPTH);
      if (m_busy && (m_n - m_fs == 10 * m_p)) m_busy = 1'b0;
      if (!m_busy && m_q.size() != 0) begin
         m_byte = m_q.pop_front();
         m_fs   = m_n;
         m_p    = (m_div == 0) ? 1 : m_div;
         m_busy = 1'b1;
      end
      if (wen) begin
         case (addr[11:0])
            12'h000: if (full_pre) m_ovf = 1'b1; else m_q.push_back(wdata[7:0]);
            12'h001: if (wdata[3]) m_ovf = 1'b0;
            12'h002: m_div = int'(wdata);
            default: ;
         endcase
      end
   endtask

   function automatic logic m_tx();
      int k;
      if (!m_busy) return 1'b1;
      k = (m_n - m_fs) / m_p;
      if (k == 0) return 1'b0;
      if (k <= 8) return m_byte[k-1];
      return 1'b1;
   endfunction

   function automatic logic [15:0] m_read(input logic [15:0] a);
      logic [4:0] c;
      c = 5'(m_q.size());
      case (a[11:0])
         12'h001: return {3'b000, c, 4'b0000, m_ovf, m_busy, (m_q.size() == 0), (m_q.size() == DEPTH)};
         12'h002: return 16'(m_div);
         default: return 16'h0000;
      endcase
   endfunction

   // Drive one bus cycle, step the model on the edge, compare on the falling edge.
   task automatic do_cycle(input logic wen, input logic [15:0] addr, input logic [15:0] wdata);
      dev_wen   = wen;
      dev_addr  = addr;
      dev_wdata = wdata;
      @(posedge clk);
      m_step(wen, addr, wdata);
      @(negedge clk);
      chk("tx", {15'b0, tx}, {15'b0, m_tx()});
      chk("rdata", dev_rdata, m_read(addr));
      dev_wen = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle(1'b0, 16'h7001, 16'h0000);
   endtask

   typedef struct {
      logic        wen;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
      logic        exp_tx;
   } vec_t;

   vec_t vt[11];

   initial begin
      // Register-map vectors from reset: reads, decode of ignored writes, divisor R/W.
      vt[0]  = '{1'b0, 16'h7001, 16'h0000, 16'h0002, 1'b1};
      vt[1]  = '{1'b0, 16'h7002, 16'h0000, 16'd434,  1'b1};
      vt[2]  = '{1'b0, 16'h7003, 16'h0000, 16'h0000, 1'b1};
      vt[3]  = '{1'b0, 16'h7000, 16'h0000, 16'h0000, 1'b1};
      vt[4]  = '{1'b0, 16'h7FFF, 16'h0000, 16'h0000, 1'b1};
      vt[5]  = '{1'b1, 16'h7002, 16'h1234, 16'h1234, 1'b1};
      vt[6]  = '{1'b1, 16'h7003, 16'h5555, 16'h0000, 1'b1};
      vt[7]  = '{1'b0, 16'h7002, 16'h0000, 16'h1234, 1'b1};
      vt[8]  = '{1'b1, 16'h7001, 16'hFFF7, 16'h0002, 1'b1};
      vt[9]  = '{1'b1, 16'h7001, 16'h0008, 16'h0002, 1'b1};
      vt[10] = '{1'b1, 16'h7002, 16'h0004, 16'h0004, 1'b1};

      m_reset();
      repeat (3) @(negedge clk);
      chk("reset tx", {15'b0, tx}, 16'h0001);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         do_cycle(vt[i].wen, vt[i].addr, vt[i].wdata);
         chk($sformatf("vec%0d rdata", i), dev_rdata, vt[i].exp_rd);
         chk($sformatf("vec%0d tx", i), {15'b0, tx}, {15'b0, vt[i].exp_tx});
      end

      // Divisor 4, byte 0x55: start bit one edge after the push, 40-clock frame.
      do_cycle(1'b1, 16'h7000, 16'h0055);
      chk("tx idle at push", {15'b0, tx}, 16'h0001);
      do_cycle(1'b0, 16'h7001, 16'h0000);
      chk("start bit", {15'b0, tx}, 16'h0000);
      chk("busy in frame", {15'b0, dev_rdata[2]}, 16'h0001);
      idle(39);
      chk("busy last stop clk", {15'b0, dev_rdata[2]}, 16'h0001);
      idle(1);
      chk("busy after frame", {15'b0, dev_rdata[2]}, 16'h0000);
      idle(4);

      // Divisor 2, three pushes in consecutive cycles: back-to-back frames.
      do_cycle(1'b1, 16'h7002, 16'h0002);
      do_cycle(1'b1, 16'h7000, 16'h00A5);
      do_cycle(1'b1, 16'h7000, 16'h003C);
      do_cycle(1'b1, 16'h7000, 16'h00FF);
      idle(1);
      chk("count after pop1", {11'b0, dev_rdata[12:8]}, 16'h0002);
      idle(64);
      chk("idle after burst", dev_rdata, 16'h0002);

      // Divisor changes mid-frame only affect later frames; divisor 0 runs 1 clock per bit.
      do_cycle(1'b1, 16'h7002, 16'h0006);
      do_cycle(1'b1, 16'h7000, 16'h0096);
      idle(27);
      do_cycle(1'b1, 16'h7002, 16'h0002);
      do_cycle(1'b1, 16'h7000, 16'h0069);
      idle(40);
      do_cycle(1'b1, 16'h7002, 16'h0000);
      do_cycle(1'b1, 16'h7000, 16'h00C3);
      idle(40);
      chk("idle after div seq", dev_rdata, 16'h0002);

      // Overflow: with a slow divisor, 9 pushes fill the FIFO after one pop; the 10th drops.
      do_cycle(1'b1, 16'h7002, 16'd1000);
      for (int i = 0; i < 10; i++) do_cycle(1'b1, 16'h7000, 16'(8'h10 + i));
      do_cycle(1'b0, 16'h7001, 16'h0000);
      chk("status overflow", dev_rdata, 16'h080D);
      do_cycle(1'b1, 16'h7001, 16'h0008);
      chk("status ovf cleared", dev_rdata, 16'h0805);

      // Asynchronous reset mid-frame with bytes queued.
      chk("tx low before reset", {15'b0, tx}, 16'h0000);
      #2 rst_n = 1'b0;
      #1;
      chk("async tx high", {15'b0, tx}, 16'h0001);
      chk("status in reset", dev_rdata, 16'h0002);
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(100);
      chk("status after reset", dev_rdata, 16'h0002);
      do_cycle(1'b0, 16'h7002, 16'h0000);
      chk("divisor after reset", dev_rdata, 16'd434);

      // Random traffic with small divisors against the model.
      do_cycle(1'b1, 16'h7002, 16'h0002);
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 4)
            do_cycle(1'b1, 16'h7000, 16'($urandom()));
         else if (r == 4)
            do_cycle(1'b1, 16'h7001, 16'($urandom()));
         else if (r == 5)
            do_cycle(1'b1, 16'h7002, 16'($urandom_range(0, 3)));
         else if (r == 6)
            do_cycle(1'b1, {4'h7, 12'($urandom_range(3, 4095))}, 16'($urandom()));
         else
            do_cycle(1'b0, {4'h7, 12'($urandom_range(0, 3))}, 16'h0000);
      end
      do_cycle(1'b1, 16'h7001, 16'h0008);
      idle(400);
      chk("final idle", dev_rdata, 16'h0002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
